// File: rtl/laser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : laser_pkg
// Brief    : Shared types and constants for the laser RX deframer.
// Revision : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam int DATA_BITS = 8;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/laser_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : laser_rx_sync
// Brief    : 2-flop synchronizer for the raw laser line plus a 3-sample
//            majority vote (two previous samples and the current one).
// Revision : 1.0 - initial release
// ============================================================================
module laser_rx_sync
    import laser_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic rx,
    output logic rxs,
    output logic maj
);

    logic       r_meta;
    logic       r_rxs;
    logic [1:0] r_hist;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= IDLE_LEVEL;
            r_rxs  <= IDLE_LEVEL;
            r_hist <= {2{IDLE_LEVEL}};
        end else begin
            r_meta <= rx;
            r_rxs  <= r_meta;
            r_hist <= {r_hist[0], r_rxs};
        end
    end

    assign rxs = r_rxs;
    // When the counter sits at HALF+1, the history holds HALF-1 and HALF.
    assign maj = maj3(r_hist[1], r_hist[0], r_rxs);

endmodule
`default_nettype wire

// File: rtl/laser_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : laser_rx_deframer
// Brief    : Async-frame byte receiver for one laser RX line; optional even
//            parity bit enabled by defining LASER_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module laser_rx_deframer
    import laser_pkg::*;
#(
    parameter int   CLKS_PER_BIT = 50,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 rx,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int                c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEC  = c_CNT_W'(CLKS_PER_BIT / 2 + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = '1;

    logic w_rxs;
    logic w_maj;

    rx_state_t             r_state,  w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [c_IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [DATA_BITS-1:0]  r_shift,  w_shift_nxt;
    logic                  r_par_err, w_par_err_nxt;
    logic [7:0]            r_data_out, w_data_out_nxt;
    logic                  r_valid,  w_valid_nxt;
    logic                  r_ferr,   w_ferr_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;

    laser_rx_sync #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .rxs   (w_rxs),
        .maj   (w_maj)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_data_out <= 8'h00;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_par_err  <= w_par_err_nxt;
            r_data_out <= w_data_out_nxt;
            r_valid    <= w_valid_nxt;
            r_ferr     <= w_ferr_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + c_ONE;
        w_idx_nxt      = r_idx;
        w_shift_nxt    = r_shift;
        w_par_err_nxt  = r_par_err;
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = 1'b0;
        w_ferr_nxt     = 1'b0;
        w_err_cnt_nxt  = r_err_cnt;

        if (!en) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    // The detect cycle counts as cnt 0 of the start bit.
                    if (w_rxs == ~IDLE_LEVEL) begin
                        w_state_nxt   = START;
                        w_cnt_nxt     = c_ONE;
                        w_par_err_nxt = 1'b0;
                    end
                end
                START: begin
                    if (r_cnt == c_DEC && w_maj == IDLE_LEVEL) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_LAST) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                    end
                end
                DATA: begin
                    if (r_cnt == c_DEC) begin
                        w_shift_nxt[r_idx] = w_maj;
                    end
                    if (r_cnt == c_LAST) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                        if (r_idx == c_IDX_LAST) begin
`ifdef LASER_RX_PARITY_EN
                            w_state_nxt = PARITY;
`else
                            w_state_nxt = STOP;
`endif
                        end
                    end
                end
`ifdef LASER_RX_PARITY_EN
                PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    if (r_cnt == c_DEC) begin
                        w_par_err_nxt = ^{r_shift, w_maj};
                    end
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = STOP;
                        w_cnt_nxt   = '0;
                    end
                end
`endif
                STOP: begin
                    // Leave at the decision point so a back-to-back start edge is not missed.
                    if (r_cnt == c_DEC) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        if (w_maj == IDLE_LEVEL && !r_par_err) begin
                            w_valid_nxt    = 1'b1;
                            w_data_out_nxt = r_shift;
                        end else begin
                            w_ferr_nxt = 1'b1;
                            if (r_err_cnt != c_ERR_MAX) begin
                                w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_valid;
    assign framing_err = r_ferr;
    assign busy        = (r_state != IDLE);
    assign err_count   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_laser_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_laser_rx_deframer
// Brief    : Directed self-checking bench for laser_rx_deframer (CPB = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_laser_rx_deframer;

    localparam int c_CPB = 8;
`ifdef LASER_RX_PARITY_EN
    localparam int c_NB  = 11;
    localparam int c_LAT = 88;
`else
    localparam int c_NB  = 10;
    localparam int c_LAT = 80;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       busy;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int both  = 0;
    int t0;
    int t1;
    int lows;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         f_cyc[$];
    logic       busy_log [0:65535];

    laser_rx_deframer #(
        .CLKS_PER_BIT (c_CPB),
        .IDLE_LEVEL   (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .busy        (busy),
        .err_count   (err_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (cyc < 65536) busy_log[cyc] = busy;
        if (data_valid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(data_out);
        end
        if (framing_err) f_cyc.push_back(cyc);
        if (data_valid && framing_err) both = both + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        v_cyc.delete();
        v_dat.delete();
        f_cyc.delete();
    endtask

    // t_start is the cycle in which the start bit appears on the pin.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input int drop_at, output int t_start);
        logic [10:0] bits;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef LASER_RX_PARITY_EN
        bits[9]   = (^d) ^ par_flip;
        bits[10]  = stop_b;
`else
        bits[9]   = stop_b;
        bits[10]  = par_flip;
`endif
        t_start = cyc;
        for (int i = 0; i < c_NB; i++) begin
            if (i == drop_at) en = 1'b0;
            rx = bits[i];
            tick(c_CPB);
        end
        rx = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        rx    = 1'b1;
        tick(3);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_valid", data_valid, 0);
        chk("rst_ferr", framing_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        reset = 1'b0;
        tick(3);

        // Single frame latency, data and busy window
        clear_logs();
        send_frame(8'hA5, 1'b1, 1'b0, -1, t0);
        tick(6);
        chk("a5_count", v_cyc.size(), 1);
        if (v_cyc.size() >= 1) begin
            chk("a5_time", v_cyc[0], t0 + c_LAT);
            chk("a5_data", v_dat[0], 8'hA5);
        end
        chk("a5_no_ferr", f_cyc.size(), 0);
        chk("a5_busy_pre", busy_log[t0+2], 0);
        chk("a5_busy_first", busy_log[t0+3], 1);
        chk("a5_busy_last", busy_log[t0+c_LAT-1], 1);
        chk("a5_busy_end", busy_log[t0+c_LAT], 0);
        lows = 0;
        for (int c = t0 + 3; c < t0 + c_LAT; c++) if (!busy_log[c]) lows = lows + 1;
        chk("a5_busy_window", lows, 0);
        chk("a5_hold", data_out, 8'hA5);

        // Back-to-back frames, zero gap
        clear_logs();
        send_frame(8'h3C, 1'b1, 1'b0, -1, t0);
        send_frame(8'hFF, 1'b1, 1'b0, -1, t1);
        tick(6);
        chk("b2b_count", v_cyc.size(), 2);
        if (v_cyc.size() >= 2) begin
            chk("b2b_time0", v_cyc[0], t0 + c_LAT);
            chk("b2b_time1", v_cyc[1], t0 + c_LAT + c_NB * c_CPB);
            chk("b2b_data0", v_dat[0], 8'h3C);
            chk("b2b_data1", v_dat[1], 8'hFF);
        end

        // Short low glitch on an idle line
        clear_logs();
        t0 = cyc;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        chk("gl_no_valid", v_cyc.size(), 0);
        chk("gl_no_ferr", f_cyc.size(), 0);
        chk("gl_busy_on", busy_log[t0+3], 1);
        chk("gl_busy_off", busy_log[t0+8], 0);
        chk("gl_err_count", err_count, 0);

        // Bad stop bit, then saturation of the error counter
        clear_logs();
        send_frame(8'h55, 1'b0, 1'b0, -1, t0);
        tick(16);
        chk("fe_count", f_cyc.size(), 1);
        if (f_cyc.size() >= 1) chk("fe_time", f_cyc[0], t0 + c_LAT);
        chk("fe_no_valid", v_cyc.size(), 0);
        chk("fe_data_hold", data_out, 8'hFF);
        chk("fe_err_count", err_count, 1);
        for (int k = 0; k < 299; k++) begin
            send_frame(8'h55, 1'b0, 1'b0, -1, t1);
            tick(16);
        end
        chk("sat_err_count", err_count, 255);
        chk("sat_ferr_count", f_cyc.size(), 300);
        chk("sat_no_valid", v_cyc.size(), 0);
        chk("sat_data_hold", data_out, 8'hFF);

        // Enable dropped mid-frame, then a clean frame
        clear_logs();
        send_frame(8'h81, 1'b1, 1'b0, 5, t1);
        tick(4);
        en = 1'b1;
        tick(4);
        send_frame(8'h42, 1'b1, 1'b0, -1, t0);
        tick(6);
        chk("en_count", v_cyc.size(), 1);
        if (v_cyc.size() >= 1) begin
            chk("en_data", v_dat[0], 8'h42);
            chk("en_time", v_cyc[0], t0 + c_LAT);
        end
        chk("en_no_ferr", f_cyc.size(), 0);
        chk("en_err_hold", err_count, 255);

        // Reset in the middle of a frame
        clear_logs();
        rx = 1'b0;
        tick(c_CPB);
        rx = 1'b1;
        tick(c_CPB);
        reset = 1'b1;
        #1;
        chk("mr_data_out", data_out, 8'h00);
        chk("mr_err_count", err_count, 0);
        chk("mr_busy", busy, 0);
        tick(3);
        reset = 1'b0;
        tick(20);
        chk("mr_no_valid", v_cyc.size(), 0);
        chk("mr_no_ferr", f_cyc.size(), 0);

`ifdef LASER_RX_PARITY_EN
        // Parity good and parity bad on 0x07
        clear_logs();
        send_frame(8'h07, 1'b1, 1'b0, -1, t0);
        tick(6);
        chk("par_ok_count", v_cyc.size(), 1);
        if (v_cyc.size() >= 1) begin
            chk("par_ok_time", v_cyc[0], t0 + 88);
            chk("par_ok_data", v_dat[0], 8'h07);
        end
        clear_logs();
        send_frame(8'h07, 1'b1, 1'b1, -1, t0);
        tick(16);
        chk("par_bad_ferr", f_cyc.size(), 1);
        if (f_cyc.size() >= 1) chk("par_bad_time", f_cyc[0], t0 + 88);
        chk("par_bad_no_valid", v_cyc.size(), 0);
        chk("par_bad_err_count", err_count, 1);
        chk("par_bad_data_hold", data_out, 8'h07);
`endif

        chk("no_overlap", both, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
